// File: rtl/jtkiwi_pkg.sv
// Shared definitions for the Kiwi shared-RAM arbiter.
// State encoding, owner encoding and open-bus value.
package jtkiwi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DATA = 2'd2
    } shr_state_e;

    localparam logic OWN_MAIN = 1'b0;
    localparam logic OWN_SUB  = 1'b1;

    localparam logic [7:0] SHR_OPEN_BUS = 8'hFF;

endpackage

// File: rtl/jtkiwi_shram_arb.sv
// Round-robin arbiter between main and sub CPU for the shared RAM.
// CPU cycles are stretched through *_wait until the access completes.
module jtkiwi_shram_arb
    import jtkiwi_pkg::*;
#(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          mshramen,
    input  logic          main_cs,
    input  logic          main_rnw,
    input  logic [AW-1:0] main_addr,
    input  logic [DW-1:0] main_din,
    output logic [DW-1:0] main_dout,
    output logic          main_wait,
    input  logic          sub_cs,
    input  logic          sub_rnw,
    input  logic [AW-1:0] sub_addr,
    input  logic [DW-1:0] sub_din,
    output logic [DW-1:0] sub_dout,
    output logic          sub_wait,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [DW-1:0] OPEN_BUS = DW'(SHR_OPEN_BUS);

    shr_state_e    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] main_dout_q, main_dout_d;
    logic [DW-1:0] sub_dout_q, sub_dout_d;
    logic          main_served_q, main_served_d;
    logic          sub_served_q, sub_served_d;

    logic main_pend, sub_pend, sub_gated, grant_sub;
    logic main_set, sub_set;

    assign main_pend = main_cs & ~main_served_q;
    assign sub_pend  = sub_cs & ~sub_served_q & mshramen;
    // With the sub CPU locked out it sees open bus in one clock
    assign sub_gated = sub_cs & ~sub_served_q & ~mshramen;
    assign grant_sub = sub_pend & (~main_pend | (last_q == OWN_MAIN));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        ram_we_d    = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;
        main_dout_d = main_dout_q;
        sub_dout_d  = sub_dout_q;
        main_set    = 1'b0;
        sub_set     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (main_pend | sub_pend) begin
                    owner_d  = grant_sub;
                    last_d   = grant_sub;
                    addr_d   = grant_sub ? sub_addr : main_addr;
                    din_d    = grant_sub ? sub_din : main_din;
                    we_d     = grant_sub ? ~sub_rnw : ~main_rnw;
                    ram_we_d = we_d;
                    state_d  = ST_ACC;
                end
            end
            ST_ACC: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (owner_q == OWN_MAIN && main_cs) begin
                    main_set = 1'b1;
                    if (!we_q) main_dout_d = ram_dout;
                end
                if (owner_q == OWN_SUB && sub_cs) begin
                    sub_set = 1'b1;
                    if (!we_q) sub_dout_d = ram_dout;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (sub_gated) sub_dout_d = OPEN_BUS;
        main_served_d = main_cs & (main_served_q | main_set);
        sub_served_d  = sub_cs & (sub_served_q | sub_set | sub_gated);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_MAIN;
            last_q        <= OWN_SUB;
            we_q          <= 1'b0;
            ram_we_q      <= 1'b0;
            addr_q        <= '0;
            din_q         <= '0;
            main_dout_q   <= OPEN_BUS;
            sub_dout_q    <= OPEN_BUS;
            main_served_q <= 1'b0;
            sub_served_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            we_q          <= we_d;
            ram_we_q      <= ram_we_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            main_dout_q   <= main_dout_d;
            sub_dout_q    <= sub_dout_d;
            main_served_q <= main_served_d;
            sub_served_q  <= sub_served_d;
        end
    end

    assign main_wait = main_cs & ~main_served_q;
    assign sub_wait  = sub_cs & ~sub_served_q;
    assign main_dout = main_dout_q;
    assign sub_dout  = sub_dout_q;
    assign ram_addr  = addr_q;
    assign ram_din   = din_q;
    assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_jtkiwi_shram_arb.sv
// Bench for the shared-RAM arbiter with a behavioural synchronous RAM.
// Read results are checked through per-CPU expected-data queues.
module tb_jtkiwi_shram_arb;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mshramen = 1'b1;
    logic        main_cs = 1'b0, main_rnw = 1'b1;
    logic [12:0] main_addr = '0;
    logic [7:0]  main_din = '0;
    logic [7:0]  main_dout;
    logic        main_wait;
    logic        sub_cs = 1'b0, sub_rnw = 1'b1;
    logic [12:0] sub_addr = '0;
    logic [7:0]  sub_din = '0;
    logic [7:0]  sub_dout;
    logic        sub_wait;
    logic [12:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_dout = '0;

    logic [7:0] mem [0:8191];
    logic [7:0] main_q [$];
    logic [7:0] sub_q [$];
    int checks = 0;
    int errors = 0;
    int we_count = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
        if (ram_we) we_count <= we_count + 1;
    end

    jtkiwi_shram_arb #(.AW(13), .DW(8)) dut (
        .clk(clk), .rstn(rstn), .mshramen(mshramen),
        .main_cs(main_cs), .main_rnw(main_rnw),
        .main_addr(main_addr), .main_din(main_din),
        .main_dout(main_dout), .main_wait(main_wait),
        .sub_cs(sub_cs), .sub_rnw(sub_rnw),
        .sub_addr(sub_addr), .sub_din(sub_din),
        .sub_dout(sub_dout), .sub_wait(sub_wait),
        .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_we(ram_we), .ram_dout(ram_dout)
    );

    task automatic access(input bit who, input bit rnw,
                          input logic [12:0] a, input logic [7:0] d,
                          output int lat, output logic [7:0] q);
        @(posedge clk); #1;
        if (who) begin
            sub_cs = 1; sub_rnw = rnw; sub_addr = a; sub_din = d;
        end else begin
            main_cs = 1; main_rnw = rnw; main_addr = a; main_din = d;
        end
        #1;
        lat = 0;
        while ((who ? sub_wait : main_wait) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        q = who ? sub_dout : main_dout;
        if (who) sub_cs = 0; else main_cs = 0;
    endtask

    task automatic do_read(input bit who, input logic [12:0] a,
                           input logic [7:0] expv, input int exp_lat,
                           input string nm);
        int lat;
        logic [7:0] q, e;
        if (who) sub_q.push_back(expv); else main_q.push_back(expv);
        access(who, 1'b1, a, 8'h00, lat, q);
        e = who ? sub_q.pop_front() : main_q.pop_front();
        checks++;
        if (q !== e) begin
            errors++;
            $display("FAIL %s data: got %h expected %h", nm, q, e);
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", nm, lat, exp_lat);
        end
    endtask

    task automatic do_write(input bit who, input logic [12:0] a,
                            input logic [7:0] d);
        int lat;
        logic [7:0] q;
        access(who, 1'b0, a, d, lat, q);
    endtask

    task automatic chk_reset_outs(input string nm);
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== 13'h0 || ram_din !== 8'h00 ||
            main_dout !== 8'hFF || sub_dout !== 8'hFF ||
            main_wait !== 1'b0 || sub_wait !== 1'b0) begin
            errors++;
            $display("FAIL %s: got we=%b a=%h d=%h md=%h sd=%h mw=%b sw=%b expected 0 0 0 ff ff 0 0",
                     nm, ram_we, ram_addr, ram_din, main_dout, sub_dout,
                     main_wait, sub_wait);
        end
    endtask

    task automatic apply_reset();
        main_cs = 0; sub_cs = 0; mshramen = 1;
        rstn = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1;
    endtask

    task automatic test_reset();
        rstn = 0;
        repeat (2) @(posedge clk);
        #1 chk_reset_outs("reset");
        rstn = 1;
        @(posedge clk); #1;
        chk_reset_outs("after_reset");
    endtask

    task automatic test_write_read();
        int lat, w0;
        logic [7:0] q;
        w0 = we_count;
        access(1'b0, 1'b0, 13'h0123, 8'h5A, lat, q);
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL wr_latency: got %0d expected 3", lat);
        end
        checks++;
        if (we_count - w0 != 1) begin
            errors++;
            $display("FAIL wr_we_pulses: got %0d expected 1", we_count - w0);
        end
        w0 = we_count;
        do_read(1'b0, 13'h0123, 8'h5A, 3, "main_read");
        checks++;
        if (we_count != w0) begin
            errors++;
            $display("FAIL rd_no_we: got %0d expected %0d", we_count, w0);
        end
        do_write(1'b0, 13'h0000, 8'h11);
        do_write(1'b0, 13'h0010, 8'hAA);
        do_write(1'b0, 13'h0020, 8'hBB);
        do_write(1'b0, 13'h0066, 8'h00);
    endtask

    task automatic contend(input logic [12:0] ma, input logic [12:0] sa,
                           input int exp_m, input int exp_s,
                           input string nm);
        int mfall, sfall;
        logic [7:0] e;
        mfall = -1; sfall = -1;
        @(posedge clk); #1;
        main_cs = 1; main_rnw = 1; main_addr = ma;
        sub_cs = 1; sub_rnw = 1; sub_addr = sa;
        for (int n = 0; n <= 12; n++) begin
            #1;
            if (!main_wait && mfall < 0) begin
                mfall = n;
                e = main_q.pop_front();
                checks++;
                if (main_dout !== e) begin
                    errors++;
                    $display("FAIL %s main_data: got %h expected %h", nm, main_dout, e);
                end
            end
            if (!sub_wait && sfall < 0) begin
                sfall = n;
                e = sub_q.pop_front();
                checks++;
                if (sub_dout !== e) begin
                    errors++;
                    $display("FAIL %s sub_data: got %h expected %h", nm, sub_dout, e);
                end
            end
            @(posedge clk); #0;
        end
        #1;
        main_cs = 0; sub_cs = 0;
        checks++;
        if (mfall != exp_m || sfall != exp_s) begin
            errors++;
            $display("FAIL %s fall: got main=%0d sub=%0d expected main=%0d sub=%0d",
                     nm, mfall, sfall, exp_m, exp_s);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        main_q.push_back(8'hAA);
        sub_q.push_back(8'hBB);
        contend(13'h0010, 13'h0020, 3, 6, "tie1");
        do_read(1'b0, 13'h0123, 8'h5A, 3, "main_solo");
        main_q.push_back(8'hBB);
        sub_q.push_back(8'hAA);
        contend(13'h0020, 13'h0010, 6, 3, "tie2");
    endtask

    task automatic test_gated();
        int w0, lat;
        logic [7:0] q;
        mshramen = 0;
        w0 = we_count;
        do_read(1'b1, 13'h0000, 8'hFF, 1, "gated_read");
        access(1'b1, 1'b0, 13'h0000, 8'h77, lat, q);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL gated_wr_latency: got %0d expected 1", lat);
        end
        checks++;
        if (we_count != w0) begin
            errors++;
            $display("FAIL gated_we: got %0d expected %0d", we_count, w0);
        end
        mshramen = 1;
        do_read(1'b0, 13'h0000, 8'h11, 3, "gated_ram_kept");
    endtask

    task automatic test_held_cs();
        int w0, bad;
        w0 = we_count;
        bad = 0;
        @(posedge clk); #1;
        main_cs = 1; main_rnw = 0; main_addr = 13'h0055; main_din = 8'h99;
        for (int n = 0; n <= 10; n++) begin
            #1;
            if (main_wait !== (n < 3)) bad++;
            @(posedge clk); #0;
        end
        #1 main_cs = 0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL held_wait: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (we_count - w0 != 1) begin
            errors++;
            $display("FAIL held_accesses: got %0d expected 1", we_count - w0);
        end
        do_read(1'b0, 13'h0055, 8'h99, 3, "held_readback");
    endtask

    task automatic test_drop_mid();
        int w0;
        w0 = we_count;
        @(posedge clk); #1;
        sub_cs = 1; sub_rnw = 0; sub_addr = 13'h0040; sub_din = 8'h3C;
        @(posedge clk); #1;
        checks++;
        if (ram_we !== 1'b1) begin
            errors++;
            $display("FAIL drop_acc_we: got %b expected 1", ram_we);
        end
        sub_cs = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut.sub_served_q !== 1'b0) begin
            errors++;
            $display("FAIL drop_served: got %b expected 0", dut.sub_served_q);
        end
        checks++;
        if (we_count - w0 != 1) begin
            errors++;
            $display("FAIL drop_writes: got %0d expected 1", we_count - w0);
        end
        do_read(1'b0, 13'h0040, 8'h3C, 3, "drop_readback");
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = we_count;
        @(posedge clk); #1;
        main_cs = 1; main_rnw = 0; main_addr = 13'h0066; main_din = 8'hE7;
        @(posedge clk); #1;
        checks++;
        if (ram_we !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_acc_we: got %b expected 1", ram_we);
        end
        #2 rstn = 0;
        main_cs = 0;
        #1 chk_reset_outs("rstmid_immediate");
        repeat (2) @(posedge clk);
        #1 chk_reset_outs("rstmid_held");
        rstn = 1;
        checks++;
        if (we_count != w0) begin
            errors++;
            $display("FAIL rstmid_no_write: got %0d expected %0d", we_count, w0);
        end
        do_read(1'b0, 13'h0066, 8'h00, 3, "rstmid_readback");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_gated();
        test_held_cs();
        test_drop_mid();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtkiwi_shram_arb.md
# jtkiwi_shram_arb

Arbiter for the 8 kB shared RAM between the main CPU and the sub/sound CPU. It sits between both CPU shared-RAM ports and a single-port synchronous RAM instance. It serialises accesses with round-robin priority and stretches each CPU's bus cycle through a wait output until its access completes. The main CPU's `mshramen` gates whether the sub CPU may reach the RAM at all.

## Interface
Parameters:
- AW, 13, RAM address width
- DW, 8, data width

Ports:
- clk  in  1  system clock (24 MHz domain)
- rstn  in  1  reset; asynchronous assertion, active-low
- mshramen  in  1  1 = sub CPU allowed to access RAM
- main_cs  in  1  main CPU shared-RAM select, held for the whole bus cycle
- main_rnw  in  1  1 = read
- main_addr  in  AW  address
- main_din  in  DW  write data from main CPU
- main_dout  out  DW  read data to main CPU, registered
- main_wait  out  1  stall request to main CPU
- sub_cs, sub_rnw, sub_addr, sub_din, sub_dout, sub_wait: same as the main_* ports, for the sub CPU
- ram_addr  out  AW  RAM address, registered
- ram_din  out  DW  RAM write data, registered
- ram_we  out  1  RAM write strobe, one clock per write
- ram_dout  in  DW  RAM read data, valid one clock after its address is presented

## Operation
- FSM states are IDLE, ACC and DATA; reset state is IDLE.
- **IDLE**
  - A requester is pending when `cs & ~served`.
  - If both are pending, the one not granted last wins. `last` resets to SUB, so main wins the first tie.
  - On a grant, register addr, din and `we = ~rnw`, set `owner` and `last`, then go to ACC.
- **ACC**
  - `ram_we` is high for this clock only if `we` is set.
  - Always go to DATA next.
- **DATA**
  - On a read, latch `ram_dout` into the owner's dout.
  - Set the owner's `served` flag only if its cs is still high.
  - Return to IDLE.
- **served flags**
  - A flag is cleared on any clock where its cs is low.
  - It prevents one held cs from being serviced twice.
- **Wait outputs**
  - `main_wait = main_cs & ~main_served` (combinational).
  - `sub_wait = sub_cs & ~sub_served` (combinational).
- **mshramen = 0**
  - A sub request bypasses the FSM.
  - In the next clock, `sub_served` is set and `sub_dout` becomes 8'hFF; writes are dropped.
  - This may happen in any FSM state and does not touch RAM or `last`.
- **cs drops mid-access**
  - The access completes at the RAM; a write is still performed.
  - Read data is discarded and `served` is not set.
- **Simultaneous events**
  - A new request arriving while the FSM is in ACC or DATA waits for IDLE.
  - A cs that drops and rises again within one clock is treated as one cycle. The CPUs guarantee at least one clock of cs low between cycles.
- **Reset values**
  - Reset is asynchronous mid-operation; any access in flight is abandoned.
  - state = IDLE, `ram_we` = 0, `ram_addr` = 0, `ram_din` = 0.
  - `main_dout` = `sub_dout` = 8'hFF.
  - Both served flags = 0, `last` = SUB.

## Timing
- Uncontended access
  - Cycle 0: cs seen, grant.
  - Cycle 1: ACC; RAM address and `we` presented.
  - Cycle 2: DATA; dout latched.
  - Cycle 3: wait low.
  - Latency is 3 clocks from cs to wait low.
- Contended access
  - The loser is granted in the cycle the winner's `served` is set (cycle 3).
  - Worst-case wait is 6 clocks.
- Throughput: one access per 3 clocks; IDLE lasts at least one clock between grants.
- Gated sub access (`mshramen` = 0): wait is high for exactly 1 clock.
- `ram_we` never lasts more than 1 clock per grant.
- `ram_addr` is stable from ACC through DATA.

## Structure
- Single module; RAM storage is the `jtframe_ram` instance in the parent game module.
- Shared package `jtkiwi_pkg` holds:
  - the FSM state enum (IDLE/ACC/DATA);
  - the owner encoding (MAIN = 0, SUB = 1);
  - the constant `SHR_OPEN_BUS` = 8'hFF.
- No sub-module.

## Test plan
- Main write 8'h5A to 13'h0123, then main read of 13'h0123 → `ram_we` pulses once at cycle 1, read returns 8'h5A, and wait is high for 3 clocks each time.
- Main and sub cs rise in the same clock after reset → main is granted first and sub's wait falls 3 clocks after main's. On the next simultaneous request, sub wins.
- `mshramen` = 0, sub reads 13'h0000 holding 8'h11 → `sub_dout` = 8'hFF, wait is high for 1 clock, and `ram_we` stays 0. A sub write leaves RAM unchanged.
- Main cs held for 10 clocks → exactly one RAM access occurs and wait stays low after cycle 3.
- Sub write in flight, cs dropped during ACC → RAM is written once and `sub_served` stays 0.
- `rstn` asserted during ACC of a write → `ram_we` goes 0 immediately, and all outputs show their reset values until `rstn` releases.
